// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter
// ---------------------------------------------------------------------------
// Round-robin arbiter that shares one WIDTH-bit bank of master-slave JK
// flip-flops between NREQ requesters. Each transaction takes four cycles:
//   IDLE   : pick a winner (round robin starting at ptr) and latch its J/K.
//   APPLY  : drive the latched J/K onto the bank for one cycle, pulse gnt[w].
//   SETTLE : drive J=K=0 so the bank holds while master/slave transfer ends.
//   REPORT : pulse done[w] with rdata = bank q captured on entry to REPORT.
//
// Handshake: req[i] is a level request. It is sampled only in IDLE. Once a
// requester is granted, the transaction always runs to completion and done[i]
// pulses even if req[i] drops. The requester should lower req[i] after its
// done pulse, otherwise it simply requests again.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   req       : [NREQ] per-requester request levels
//   cmd_j     : [NREQ*WIDTH] J vectors, requester i at [i*WIDTH +: WIDTH]
//   cmd_k     : [NREQ*WIDTH] K vectors, same packing as cmd_j
//   q_in      : [WIDTH] current q of the JK bank
//   j_out     : [WIDTH] J lines to the bank
//   k_out     : [WIDTH] K lines to the bank
//   gnt       : [NREQ] one-hot pulse during the winner's APPLY cycle
//   done      : [NREQ] one-hot pulse during the winner's REPORT cycle
//   rdata     : [WIDTH] bank q returned to the winner, held until next done
//   busy      : high in every state except IDLE
//   state_dbg : [2] current FSM state (IDLE=0, APPLY=1, SETTLE=2, REPORT=3)
// ---------------------------------------------------------------------------
module jk_bank_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   cmd_j,
   input  logic [NREQ*WIDTH-1:0]   cmd_k,
   input  logic [WIDTH-1:0]        q_in,
   output logic [WIDTH-1:0]        j_out,
   output logic [WIDTH-1:0]        k_out,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         done,
   output logic [WIDTH-1:0]        rdata,
   output logic                    busy,
   output logic [1:0]              state_dbg
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_APPLY  = 2'd1;
   localparam logic [1:0] ST_SETTLE = 2'd2;
   localparam logic [1:0] ST_REPORT = 2'd3;

   localparam logic [NREQ-1:0]  ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

   logic [1:0]        state;
   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  win_q;

   // Combinational winner search and command slice selection.
   logic              any_req;
   logic [PTR_W-1:0]  win_c;
   logic [WIDTH-1:0]  sel_j;
   logic [WIDTH-1:0]  sel_k;

   // First asserted request scanning ptr, ptr+1, ... wrapping at NREQ.
   always_comb begin
      int               idx;
      logic [PTR_W-1:0] idx_b;
      any_req = 1'b0;
      win_c   = '0;
      idx     = 0;
      idx_b   = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         idx_b = PTR_W'(idx);
         if (!any_req && req[idx_b]) begin
            any_req = 1'b1;
            win_c   = idx_b;
         end
      end
   end

   // Mux the winning requester's J/K slice.
   always_comb begin
      sel_j = '0;
      sel_k = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_c == PTR_W'(i)) begin
            sel_j = cmd_j[i*WIDTH +: WIDTH];
            sel_k = cmd_k[i*WIDTH +: WIDTH];
         end
      end
   end

   // All outputs are registered; each state sets up the outputs of the next.
   // The J/K registers themselves serve as the command latch, so later
   // changes on cmd_* cannot reach the bank for the current transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         ptr   <= '0;
         win_q <= '0;
         j_out <= '0;
         k_out <= '0;
         gnt   <= '0;
         done  <= '0;
         rdata <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= '0;
               if (any_req) begin
                  state <= ST_APPLY;
                  win_q <= win_c;
                  j_out <= sel_j;
                  k_out <= sel_k;
                  gnt   <= ONE_HOT0 << win_c;
                  busy  <= 1'b1;
               end else begin
                  j_out <= '0;
                  k_out <= '0;
                  gnt   <= '0;
                  busy  <= 1'b0;
               end
            end

            ST_APPLY: begin
               // Bank captures J/K on this edge; hold it afterwards.
               state <= ST_SETTLE;
               j_out <= '0;
               k_out <= '0;
               gnt   <= '0;
            end

            ST_SETTLE: begin
               // q_in now reflects the applied command.
               state <= ST_REPORT;
               rdata <= q_in;
               done  <= ONE_HOT0 << win_q;
               ptr   <= (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
            end

            ST_REPORT: begin
               state <= ST_IDLE;
               done  <= '0;
               busy  <= 1'b0;
            end

            default: begin
               state <= ST_IDLE;
               j_out <= '0;
               k_out <= '0;
               gnt   <= '0;
               done  <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
module tb_jk_bank_arbiter;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd2;

   logic                  clk;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] cmd_j;
   logic [NREQ*WIDTH-1:0] cmd_k;
   logic [WIDTH-1:0]      q_in;
   logic [WIDTH-1:0]      j_out;
   logic [WIDTH-1:0]      k_out;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;
   logic [WIDTH-1:0]      rdata;
   logic                  busy;
   logic [1:0]            state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- JK bank model ----------------
   logic [WIDTH-1:0] bank_q;
   logic             bank_ld;
   logic [WIDTH-1:0] bank_ld_val;

   always @(posedge clk) begin
      if (bank_ld) bank_q <= bank_ld_val;
      else         bank_q <= (j_out & ~bank_q) | (~k_out & bank_q);
   end
   assign q_in = bank_q;

   jk_bank_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk(clk), .rst(rst), .req(req), .cmd_j(cmd_j), .cmd_k(cmd_k),
      .q_in(q_in), .j_out(j_out), .k_out(k_out), .gnt(gnt), .done(done),
      .rdata(rdata), .busy(busy), .state_dbg(state_dbg)
   );

   // ---------------- driver / check tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_bank(input logic [WIDTH-1:0] v);
      bank_ld     = 1'b1;
      bank_ld_val = v;
      step();
      bank_ld     = 1'b0;
   endtask

   // One-hot exclusivity of gnt/done every cycle outside reset.
   always @(negedge clk) begin
      if (!rst && cyc > 2) begin
         chk("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
         chk("done_onehot0", {31'd0, $onehot0(done)}, 32'd1);
         chk("gnt_done_excl", {31'd0, (|gnt) && (|done)}, 32'd0);
      end
   end

   // ---------------- directed sequence ----------------
   int exp_w[6] = '{0, 1, 2, 3, 0, 1};
   int last_done;

   initial begin
      rst = 1'b1; req = '0; cmd_j = '0; cmd_k = '0;
      bank_ld = 1'b1; bank_ld_val = 8'h00;
      step(); step();
      chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
      chk("rst_j", 32'(j_out), 32'h0);
      chk("rst_k", 32'(k_out), 32'h0);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_rdata", 32'(rdata), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rst = 1'b0; bank_ld = 1'b0;
      step();

      // Basic set: bank 0x00, req0 with J=FF K=00.
      req = 4'b0001; cmd_j[0 +: 8] = 8'hFF; cmd_k[0 +: 8] = 8'h00;
      step();
      chk("basic_gnt", 32'(gnt), 32'h1);
      chk("basic_j", 32'(j_out), 32'hFF);
      chk("basic_k", 32'(k_out), 32'h00);
      chk("basic_busy1", 32'(busy), 32'h1);
      step();
      chk("basic_settle_j", 32'(j_out), 32'h0);
      chk("basic_settle_k", 32'(k_out), 32'h0);
      chk("basic_settle_gnt", 32'(gnt), 32'h0);
      step();
      chk("basic_done", 32'(done), 32'h1);
      chk("basic_rdata", 32'(rdata), 32'hFF);
      req = '0;
      step();
      chk("basic_busy4", 32'(busy), 32'h0);
      chk("basic_done_clr", 32'(done), 32'h0);
      chk("basic_rdata_hold", 32'(rdata), 32'hFF);

      // Toggle twice from 0xA5.
      load_bank(8'hA5);
      req = 4'b0001; cmd_j[0 +: 8] = 8'hFF; cmd_k[0 +: 8] = 8'hFF;
      step();
      chk("tog1_j", 32'(j_out), 32'hFF);
      chk("tog1_k", 32'(k_out), 32'hFF);
      step(); step();
      chk("tog1_done", 32'(done), 32'h1);
      chk("tog1_rdata", 32'(rdata), 32'h5A);
      req = '0;
      step();
      req = 4'b0001;
      step(); step(); step();
      chk("tog2_done", 32'(done), 32'h1);
      chk("tog2_rdata", 32'(rdata), 32'hA5);
      req = '0;
      step();

      // Fairness from ptr=0 after a reset.
      rst = 1'b1; step(); rst = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         cmd_j[i*WIDTH +: WIDTH] = 8'(i + 1);
         cmd_k[i*WIDTH +: WIDTH] = 8'h00;
      end
      req = 4'b1111;
      last_done = 0;
      for (int t = 0; t < 6; t++) begin
         step();
         chk($sformatf("fair_gnt%0d", t), 32'(gnt), 32'(4'b0001 << exp_w[t]));
         chk($sformatf("fair_j%0d", t), 32'(j_out), 32'(exp_w[t] + 1));
         step(); step();
         chk($sformatf("fair_done%0d", t), 32'(done), 32'(4'b0001 << exp_w[t]));
         if (t > 0) chk($sformatf("fair_space%0d", t), 32'(cyc - last_done), 32'd4);
         last_done = cyc;
         req[exp_w[t]] = 1'b0;
         step();
         req[exp_w[t]] = 1'b1;
      end
      req = '0;
      step();

      // ptr is now 2: serve req2 -> ptr 3, then req=0101 serves 0 then 2.
      req = 4'b0100;
      step();
      chk("wrap_gnt2", 32'(gnt), 32'h4);
      step(); step();
      chk("wrap_done2", 32'(done), 32'h4);
      req = '0;
      step();
      req = 4'b0101;
      step();
      chk("skip_gnt0", 32'(gnt), 32'h1);
      step(); step();
      chk("skip_done0", 32'(done), 32'h1);
      req[0] = 1'b0;
      step();
      step();
      chk("skip_gnt2", 32'(gnt), 32'h4);
      step(); step();
      chk("skip_done2", 32'(done), 32'h4);
      req = '0;
      step();

      // Reset during SETTLE; ptr (was 3) must return to 0.
      req = 4'b0001;
      step(); step();
      chk("mid_in_settle", 32'(state_dbg), 32'(ST_SETTLE));
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_state", 32'(state_dbg), 32'(ST_IDLE));
      chk("mid_done", 32'(done), 32'h0);
      chk("mid_j", 32'(j_out), 32'h0);
      chk("mid_k", 32'(k_out), 32'h0);
      chk("mid_busy", 32'(busy), 32'h0);
      req = 4'b1001;
      step();
      chk("mid_regnt0", 32'(gnt), 32'h1);
      step(); step();
      chk("mid_redone0", 32'(done), 32'h1);
      req[0] = 1'b0;
      step();
      step();
      chk("mid_gnt3", 32'(gnt), 32'h8);
      step(); step();
      chk("mid_done3", 32'(done), 32'h8);
      req = '0;
      step();

      // Late cmd change and dropped req on requester 1 (ptr now 0).
      load_bank(8'h00);
      req = 4'b0010; cmd_j[1*WIDTH +: WIDTH] = 8'h0F; cmd_k[1*WIDTH +: WIDTH] = 8'h00;
      step();
      chk("late_gnt", 32'(gnt), 32'h2);
      chk("late_j", 32'(j_out), 32'h0F);
      cmd_j[1*WIDTH +: WIDTH] = 8'hF0;
      step();
      chk("late_bank", 32'(bank_q), 32'h0F);
      req = '0;
      step();
      chk("drop_done", 32'(done), 32'h2);
      chk("late_rdata", 32'(rdata), 32'h0F);
      step();
      chk("end_busy", 32'(busy), 32'h0);
      chk("end_rdata_hold", 32'(rdata), 32'h0F);
      step(); step();
      chk("end_idle_no_gnt", 32'(gnt), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
